// File: rtl/seg_scan_pkg.sv
// seg_pkg: shared widths and defaults for the 7-segment scanner.
package seg_pkg;
    localparam int DIGITS_DEF = 4;
    localparam int NIBBLE_W = 4;
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/seg_scan_if.sv
// seg_scan_if: load/display bus between the scanner and its user.
interface seg_scan_if #(parameter int DIGITS = seg_pkg::DIGITS_DEF);
    logic                                  load;
    logic [seg_pkg::NIBBLE_W*DIGITS-1:0]   value;
    logic [DIGITS-1:0]                     blank_mask;
    logic [seg_pkg::NIBBLE_W-1:0]          data;
    logic [DIGITS-1:0]                     dig_sel;
    logic                                  pending;
    logic                                  frame;
    modport master(output load, value, blank_mask, input data, dig_sel, pending, frame);
    modport slave(input load, value, blank_mask, output data, dig_sel, pending, frame);
endinterface

// File: rtl/seg_scan_slot_timer.sv
// slot_timer: cycle-within-slot and digit-index counters with slot-start and frame-wrap flags.
module slot_timer import seg_pkg::*; #(
    parameter int DIGITS = DIGITS_DEF,
    parameter int DIV = 1000,
    localparam int CW = cnt_w(DIV),
    localparam int IW = cnt_w(DIGITS)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [CW-1:0] o_cnt,
    output logic [IW-1:0] o_idx,
    output logic          o_slot_start,
    output logic          o_wrap
);
    logic [CW-1:0] r_cnt;
    logic [IW-1:0] r_idx;
    logic          w_cnt_last;
    logic          w_idx_last;
    assign w_cnt_last   = r_cnt == CW'(DIV - 1);
    assign w_idx_last   = r_idx == IW'(DIGITS - 1);
    assign o_cnt        = r_cnt;
    assign o_idx        = r_idx;
    assign o_slot_start = r_cnt == '0;
    assign o_wrap       = w_cnt_last && w_idx_last;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else begin
            r_cnt <= w_cnt_last ? '0 : r_cnt + 1'b1;
            if (w_cnt_last) r_idx <= w_idx_last ? '0 : r_idx + 1'b1;
        end
    end
endmodule

// File: rtl/seg_scan.sv
// seg_scan: multiplexed 7-segment scanner; loaded values are held in a shadow
// register and swapped in only at the frame boundary so a frame never mixes digits.
module seg_scan import seg_pkg::*; #(
    parameter int DIGITS = DIGITS_DEF,
    parameter int DIV = 1000,
    parameter int BLANK = 2
) (
    input logic        clk,
    input logic        rst,
    seg_scan_if.slave  bus
);
    localparam int CW = cnt_w(DIV);
    localparam int IW = cnt_w(DIGITS);
    logic [CW-1:0]                 w_cnt;
    logic [IW-1:0]                 w_idx;
    logic                          w_slot_start;
    logic                          w_wrap;
    logic [NIBBLE_W*DIGITS-1:0]    r_active;
    logic [NIBBLE_W*DIGITS-1:0]    r_shadow;
    logic                          r_pending;
    logic                          r_frame;
    slot_timer #(.DIGITS(DIGITS), .DIV(DIV)) u_timer (
        .clk(clk),
        .rst(rst),
        .o_cnt(w_cnt),
        .o_idx(w_idx),
        .o_slot_start(w_slot_start),
        .o_wrap(w_wrap)
    );
    assign bus.data    = r_active[NIBBLE_W*w_idx +: NIBBLE_W];
    assign bus.dig_sel = (w_slot_start || w_cnt < CW'(BLANK) || bus.blank_mask[w_idx])
                         ? '0 : DIGITS'(1) << w_idx;
    assign bus.pending = r_pending;
    assign bus.frame   = r_frame;
    // A load landing on the wrap cycle bypasses the shadow register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_active  <= '0;
            r_shadow  <= '0;
            r_pending <= 1'b0;
            r_frame   <= 1'b0;
        end else begin
            r_frame <= w_wrap;
            if (w_wrap && bus.load) begin
                r_active  <= bus.value;
                r_pending <= 1'b0;
            end else if (w_wrap && r_pending) begin
                r_active  <= r_shadow;
                r_pending <= 1'b0;
            end else if (bus.load) begin
                r_shadow  <= bus.value;
                r_pending <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: scoreboard bench; expected outputs are queued per cycle with the stimulus and compared as each cycle is reached.
module tb_seg_scan;
    typedef struct {int k; int sig; logic [15:0] v;} exp_t;
    typedef struct {int k; logic ld; logic [15:0] v; logic r;} stim_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t  exp_q[$];
    stim_t stim_q[$];
    int n_vec = 0;
    int n_err = 0;
    string nm[4] = '{"data", "dig_sel", "pending", "frame"};
    always #5 clk = ~clk;
    seg_scan_if #(.DIGITS(4)) bus();
    seg_scan #(.DIGITS(4), .DIV(8), .BLANK(2)) dut (.clk(clk), .rst(rst), .bus(bus));
    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask
    function automatic logic [15:0] obs(input int sig);
        return sig == 0 ? {12'd0, bus.data} : sig == 1 ? {12'd0, bus.dig_sel} :
               sig == 2 ? {15'd0, bus.pending} : {15'd0, bus.frame};
    endfunction
    task automatic ex(input int k, input int sig, input logic [15:0] v);
        exp_q.push_back('{k, sig, v});
    endtask
    task automatic st(input int k, input logic ld, input logic [15:0] v, input logic r);
        stim_q.push_back('{k, ld, v, r});
    endtask
    task automatic run(input string name, input int ncyc);
        stim_t s;
        exp_t e;
        bus.load = 1'b0;
        bus.value = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) chk($sformatf("%s.rst_%s", name, nm[i]), obs(i), 16'd0);
        rst = 1'b0;
        for (int k = 0; k < ncyc; k++) begin
            bus.load = 1'b0;
            rst = 1'b0;
            while (stim_q.size() > 0 && stim_q[0].k == k) begin
                s = stim_q.pop_front();
                bus.load = s.ld;
                bus.value = s.v;
                rst = s.r;
            end
            while (exp_q.size() > 0 && exp_q[0].k == k) begin
                e = exp_q.pop_front();
                chk($sformatf("%s.%s@%0d", name, nm[e.sig], k), obs(e.sig), e.v);
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        bus.load = 1'b0;
        chk($sformatf("%s.unreached", name), 16'(exp_q.size()), 16'd0);
        exp_q.delete();
        stim_q.delete();
    endtask
    initial begin
        bus.blank_mask = 4'b0000;
        // load 1234 mid-frame: shown from the next frame, digit 0 first
        st(3, 1'b1, 16'h1234, 1'b0);
        for (int k = 0; k < 64; k++) begin
            if (k < 2) ex(k, 1, 16'h0);
            if (k >= 2 && k <= 7) ex(k, 1, 16'h1);
            if (k >= 10 && k <= 15) ex(k, 1, 16'h2);
            if (k < 32) ex(k, 0, 16'h0);
            if (k <= 3) ex(k, 2, 16'h0);
            if (k >= 4 && k <= 31) ex(k, 2, 16'h1);
            if (k == 31 || k == 33) ex(k, 3, 16'h0);
            if (k == 32) begin
                ex(k, 0, 16'h4);
                ex(k, 2, 16'h0);
                ex(k, 3, 16'h1);
            end
            if (k == 40) ex(k, 0, 16'h3);
            if (k == 48) ex(k, 0, 16'h2);
            if (k == 56) ex(k, 0, 16'h1);
        end
        run("load", 64);
        // last load before the boundary wins
        st(5, 1'b1, 16'h1111, 1'b0);
        st(10, 1'b1, 16'h2222, 1'b0);
        for (int k = 0; k < 64; k++) begin
            if (k >= 11 && k <= 31) ex(k, 2, 16'h1);
            if (k < 32) ex(k, 0, 16'h0);
            if (k == 32) ex(k, 3, 16'h1);
            if (k >= 32) ex(k, 0, 16'h2);
        end
        run("lastwins", 64);
        // load on the wrap cycle bypasses shadow
        st(31, 1'b1, 16'hABCD, 1'b0);
        for (int k = 0; k < 42; k++) begin
            if (k <= 33) ex(k, 2, 16'h0);
            if (k == 31) ex(k, 0, 16'h0);
            if (k == 32) begin
                ex(k, 0, 16'hD);
                ex(k, 3, 16'h1);
            end
            if (k == 40) ex(k, 0, 16'hC);
        end
        run("bypass", 42);
        // reset mid-frame discards the pending value
        st(3, 1'b1, 16'h1234, 1'b0);
        st(20, 1'b0, 16'h1234, 1'b1);
        st(21, 1'b0, 16'h1234, 1'b1);
        st(22, 1'b0, 16'h1234, 1'b1);
        for (int k = 0; k < 70; k++) begin
            if (k == 19) ex(k, 2, 16'h1);
            if (k == 21 || k == 22) for (int s = 0; s < 4; s++) ex(k, s, 16'h0);
            if (k == 23 || k == 24) ex(k, 1, 16'h0);
            if (k == 23) ex(k, 2, 16'h0);
            if (k == 25) ex(k, 1, 16'h1);
            if (k == 33) ex(k, 1, 16'h2);
            if (k == 55) begin
                ex(k, 0, 16'h0);
                ex(k, 2, 16'h0);
                ex(k, 3, 16'h1);
            end
            if (k == 62) ex(k, 0, 16'h0);
        end
        run("midrst", 70);
        // digit 3 masked: never lit, but data still scans all nibbles
        bus.blank_mask = 4'b1000;
        st(0, 1'b1, 16'h4321, 1'b0);
        for (int k = 32; k < 128; k++) begin
            int c;
            int d;
            c = k % 8;
            d = (k / 8) % 4;
            ex(k, 0, (16'h4321 >> (4 * d)) & 16'hF);
            ex(k, 1, (c < 2 || d == 3) ? 16'h0 : 16'(1 << d));
            ex(k, 3, (k % 32 == 0) ? 16'h1 : 16'h0);
        end
        run("mask", 128);
        bus.blank_mask = 4'b0000;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/seg_scan.md
# seg_scan

Time-multiplexed scanner for a multi-digit 7-segment display. Holds a `DIGITS`-nibble display value and, one digit slot at a time, presents the current nibble on `data` to the downstream 4-bit-to-segment decoder while driving a one-hot digit select. New values are accepted at any time but only become visible at a frame boundary, so a frame never mixes old and new digits.

## Interface
- `DIGITS`, 4: number of digits scanned; at least 2.
- `DIV`, 1000: clock cycles per digit slot; at least 2.
- `BLANK`, 2: cycles at the start of each slot with all digits off, for anti-ghosting; 1 ≤ `BLANK` < `DIV`.

- `clk` in, 1: single clock; all state changes on its rising edge.
- `rst` in, 1: synchronous, active-high reset.
- `load` in, 1: valid strobe for `value`, sampled every cycle.
- `value` in, 4*`DIGITS`: display value; digit i is `value[4i+3:4i]`.
- `blank_mask` in, `DIGITS`: bit i = 1 keeps digit i dark; live input, not latched.
- `data` out, 4: nibble of the digit in the current slot, fed to the decoder.
- `dig_sel` out, `DIGITS`: one-hot, active-high digit enable.
- `pending` out, 1: a loaded value is waiting for the frame boundary.
- `frame` out, 1: one-cycle pulse in the first cycle of each new frame.

## Operation
- State:
  - `cnt`: 0..`DIV`-1.
  - `idx`: 0..`DIGITS`-1.
  - `active`: the displayed register.
  - `shadow`: the holding register for a loaded value.
  - `pending`: set while `shadow` holds a value not yet displayed.
- Every cycle, `cnt` increments. At `DIV`-1 it wraps to 0 and `idx` increments, wrapping `DIGITS`-1 to 0.
- The wrap cycle (W) is when `cnt`=`DIV`-1 and `idx`=`DIGITS`-1.
- Outputs:
  - `data` = `active[4*idx+3:4*idx]`, combinational from registers.
  - `dig_sel` = 0 when `cnt` < `BLANK` or `blank_mask[idx]`=1; otherwise one-hot bit `idx`.
  - `frame` is a registered copy of W.
- Load and transfer rules, with priority in this order:
  1. W with `load`=1: `active` ← `value`, `pending` ← 0. This is a bypass; `shadow` is don't-care.
  2. W with `pending`=1: `active` ← `shadow`, `pending` ← 0.
  3. Not W with `load`=1: `shadow` ← `value`, `pending` ← 1. Last load before the boundary wins.
  4. Otherwise no change.
- There is no backpressure. `load` is always accepted.
- Reset:
  - `cnt`, `idx`, `active`, `shadow`, `pending` and `frame` are all set to 0.
  - Therefore `data`=0 and `dig_sel`=0.
  - A pending value is discarded.
  - Reset mid-slot or mid-frame restarts the scan at digit 0, cnt 0.

## Timing
- Cycle k is the k-th cycle after `rst` falls (k=0 first). In it, `cnt`=k mod `DIV` and `idx`=(k div `DIV`) mod `DIGITS`.
- Frame length is `DIV`·`DIGITS` cycles.
- `frame` asserts at k = n·`DIV`·`DIGITS` for n ≥ 1. There is no pulse for the first frame after reset.
- Load-to-display latency is from a load in cycle k to the first cycle after the next W at or after k:
  - If k is itself W, `data` shows the new value at k+1.
- `pending` rises the cycle after the load and falls in the cycle `frame` is high.
- `data` switches exactly at slot start. `dig_sel` lights `BLANK` cycles later and goes dark at the next slot start.

## Structure
- Shared package `seg_pkg`:
  - Digit count default.
  - `NIBBLE_W`=4.
  - The function computing the counter width, `$clog2(DIV)`.
- One sub-module, `slot_timer`: the `cnt`/`idx` counter pair. It outputs `cnt`, `idx`, the slot-start flag and W.
- `seg_scan` instantiates `slot_timer` and holds the registers, the load logic and the output muxing.
- In the top level, `data` connects directly to the decoder input.

## Test plan
All scenarios use `DIGITS`=4, `DIV`=8, `BLANK`=2.
- Reset, then release:
  - During reset, all outputs are 0.
  - Cycles 0–1: `dig_sel`=0000.
  - Cycles 2–7: `dig_sel`=0001, `data`=0.
  - Cycles 10–15: `dig_sel`=0010.
- Load `value`=16'h1234 in cycle 3 → `pending`=1 over cycles 4–31; `data`=0 through cycle 31; cycle 32 `frame`=1, `pending`=0, `data`=4; cycle 40 `data`=3; cycle 48 `data`=2; cycle 56 `data`=1.
- Loads of 16'h1111 in cycle 5 and 16'h2222 in cycle 10 → frame starting at cycle 32 shows 2222. The value 1111 is never displayed.
- Load 16'hABCD in cycle 31 (W) → `pending` stays 0; cycle 32 `data`=D, `frame`=1.
- Load in cycle 3, `rst` high in cycle 20 → `pending`=0, `data`=0 and `dig_sel`=0 during reset; after release, scan restarts at digit 0 and `active` stays 0.
- `blank_mask`=1000 → `dig_sel` bit 3 never asserts over 3 frames; `data` still cycles through all 4 nibbles; `frame` period is 32.
